// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 timing constants, count width and lock-state type
//   used by the sync-to-count recovery block and the matching VGA sync generator.
package vga_timing_pkg;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_EDGE   = 656;
    localparam int V_EDGE   = 490;
    localparam int CNT_W    = 10;
    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} lock_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus one edge-detect flop for a raw sync pin.
//   clk, rst      : pixel clock, async active-high reset (flops go to the idle level)
//   sync          : raw sync pin
//   sync_d        : pin delayed through all three flops, polarity unchanged
//   sync_edge     : assertion edge seen between the second and third flop
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic sync_d,
    output logic sync_edge
);
    localparam logic IDLE = ACTIVE_LOW;
    logic s1, s2, s3;
    always_ff @(posedge clk or posedge rst)
        if (rst) {s1, s2, s3} <= {3{IDLE}};
        else     {s1, s2, s3} <= {sync, s1, s2};
    assign sync_d    = s3;
    assign sync_edge = (s3 == IDLE) && (s2 != IDLE);
endmodule

// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count: recover pixel column/row counts from raw HSync/VSync pins and monitor lock.
//   i_Clk, i_Rst                 : pixel clock, async active-high reset
//   i_HSync, i_VSync             : raw sync pins
//   o_HSync, o_VSync             : syncs delayed 3 cycles to align with the counts
//   o_Col_Count, o_Row_Count     : recovered position
//   o_Active                     : position inside the visible area
//   o_Frame_Start                : pulse on each VSync assertion edge
//   o_Locked, o_Sync_Err         : lock status and one-cycle pulse when lock is lost
module vga_sync_to_count
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS      = H_TOTAL,
    parameter int TOTAL_ROWS      = V_TOTAL,
    parameter int ACTIVE_COLS     = H_ACTIVE,
    parameter int ACTIVE_ROWS     = V_ACTIVE,
    parameter int H_EDGE_COL      = H_EDGE,
    parameter int V_EDGE_ROW      = V_EDGE,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_HSync,
    input  logic             i_VSync,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic [CNT_W-1:0] o_Col_Count,
    output logic [CNT_W-1:0] o_Row_Count,
    output logic             o_Active,
    output logic             o_Frame_Start,
    output logic             o_Locked,
    output logic             o_Sync_Err
);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] EDGE_COL = CNT_W'(H_EDGE_COL);
    localparam logic [CNT_W-1:0] EDGE_ROW = CNT_W'(V_EDGE_ROW);

    logic h_edge, v_edge, at_edge, err_n;
    logic [CNT_W-1:0] col, row, exp_col, exp_row;
    lock_state_t state, state_n;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_h (
        .clk(i_Clk), .rst(i_Rst), .sync(i_HSync), .sync_d(o_HSync), .sync_edge(h_edge)
    );
    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_v (
        .clk(i_Clk), .rst(i_Rst), .sync(i_VSync), .sync_d(o_VSync), .sync_edge(v_edge)
    );

    // Expected position is what free-running would produce this cycle.
    always_comb begin
        exp_col = (col == LAST_COL) ? '0 : col + 1'b1;
        exp_row = (col != LAST_COL) ? row : (row == LAST_ROW) ? '0 : row + 1'b1;
        at_edge = (exp_col == '0) && (exp_row == EDGE_ROW);
    end

    // In LOCKED, v_edge != at_edge covers both a misplaced and a missing VSync edge;
    // a bad HSync edge is an error even alongside a good VSync edge.
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            UNLOCKED: state_n = v_edge ? CHECK : UNLOCKED;
            CHECK:    state_n = (v_edge && at_edge) ? LOCKED : CHECK;
            LOCKED: begin
                err_n   = (v_edge != at_edge) || (h_edge && exp_col != EDGE_COL);
                state_n = err_n ? UNLOCKED : LOCKED;
            end
            default:  state_n = UNLOCKED;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) begin
            col           <= '0;
            row           <= '0;
            state         <= UNLOCKED;
            o_Frame_Start <= 1'b0;
            o_Sync_Err    <= 1'b0;
        end else begin
            col           <= v_edge ? '0 : exp_col;
            row           <= v_edge ? EDGE_ROW : exp_row;
            state         <= state_n;
            o_Frame_Start <= v_edge;
            o_Sync_Err    <= err_n;
        end

    assign o_Col_Count = col;
    assign o_Row_Count = row;
    assign o_Active    = (col < ACT_COLS) && (row < ACT_ROWS);
    assign o_Locked    = (state == LOCKED);
endmodule

// File: tb/tb_vga_sync_to_count.sv
// tb_vga_sync_to_count: randomized sync generator against a position/lock model, plus pinned literals.
module tb_vga_sync_to_count;
    localparam int TC = 40, TR = 20, AC = 32, AR = 15, HE = 34, VE = 17;
    logic clk = 0, rst = 0, hs_pin = 1, vs_pin = 1;
    logic hs_o, vs_o, active, frame_start, locked, sync_err;
    logic [9:0] col, row;
    always #5 clk = ~clk;

    vga_sync_to_count #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_EDGE_COL(HE), .V_EDGE_ROW(VE), .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_pin), .i_VSync(vs_pin),
        .o_HSync(hs_o), .o_VSync(vs_o), .o_Col_Count(col), .o_Row_Count(row),
        .o_Active(active), .o_Frame_Start(frame_start), .o_Locked(locked), .o_Sync_Err(sync_err)
    );

    int checks = 0, failures = 0, cyc = 0;
    int m_pos, m_lock, m_frame, m_err;
    int hq[$], vq[$];
    typedef struct {int step; int what; int val;} lit_t;
    lit_t lits[$];
    string lname[6] = '{"lit_col", "lit_row", "lit_active", "lit_locked", "lit_err", "lit_frame"};
    int gc = 0, gr = 0, frame_no = 0, mode = 0, bad_row = 1, vcnt = 0, rc = 0;
    bit lock_lit = 0, fs_lit = 0, did_rst = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic lit(int dly, int what, int val);
        lit_t l;
        l.step = cyc + dly; l.what = what; l.val = val;
        lits.push_back(l);
    endtask

    task automatic model_reset();
        m_pos = 0; m_lock = 0; m_frame = 0; m_err = 0;
        hq = '{1, 1, 1, 1};
        vq = '{1, 1, 1, 1};
    endtask

    // Position is a single linear pixel index; pins show up 3 samples later.
    task automatic model_tick();
        int n, nxt;
        bit he, ve, at;
        hq.push_back(int'(hs_pin));
        vq.push_back(int'(vs_pin));
        if (hq.size() > 8) begin void'(hq.pop_front()); void'(vq.pop_front()); end
        n  = hq.size();
        he = hq[n-3] == 0 && hq[n-4] == 1;
        ve = vq[n-3] == 0 && vq[n-4] == 1;
        nxt = (m_pos + 1) % (TC * TR);
        at  = nxt == VE * TC;
        m_err = 0;
        if (m_lock == 2 && (ve != at || (he && nxt % TC != HE))) begin
            m_err = 1; m_lock = 0;
        end else if (ve && (m_lock == 0 || at)) m_lock = (m_lock == 0) ? 1 : 2;
        m_pos   = ve ? VE * TC : nxt;
        m_frame = ve;
    endtask

    function automatic int lit_act(int what);
        case (what)
            0: return int'(col);
            1: return int'(row);
            2: return int'(active);
            3: return int'(locked);
            4: return int'(sync_err);
            default: return int'(frame_start);
        endcase
    endfunction

    task automatic compare();
        lit_t keep[$];
        int c, r;
        c = m_pos % TC; r = m_pos / TC;
        chk("col", int'(col), c);
        chk("row", int'(row), r);
        chk("active", int'(active), int'(c < AC && r < AR));
        chk("hsync", int'(hs_o), hq[hq.size()-3]);
        chk("vsync", int'(vs_o), vq[vq.size()-3]);
        chk("frame_start", int'(frame_start), m_frame);
        chk("locked", int'(locked), int'(m_lock == 2));
        chk("sync_err", int'(sync_err), m_err);
        foreach (lits[i])
            if (lits[i].step == cyc) chk(lname[lits[i].what], lit_act(lits[i].what), lits[i].val);
            else keep.push_back(lits[i]);
        lits = keep;
    endtask

    task automatic gen_drive();
        int hstart, vrow, r;
        bit scripted;
        if (gc == 0 && gr == 0) begin
            r = $urandom_range(0, 7);
            mode = frame_no == 12 ? 1 : frame_no == 16 ? 2 : frame_no == 20 ? 3 :
                   (frame_no >= 24 && frame_no < 44) ? (r > 3 ? 0 : r) : 0;
            bad_row = $urandom_range(1, 14);
        end
        scripted = frame_no < 24;
        hstart = (mode == 3 && gr == bad_row) ? HE - 4 : HE;
        vrow   = (mode == 1) ? VE + 1 : VE;
        hs_pin = !(gc >= hstart && gc < HE + 4);
        vs_pin = !(mode != 2 && (gr == vrow || gr == vrow + 1));
        if (gc == 0 && gr == vrow && mode != 2 && !rst) begin
            vcnt++;
            if (vcnt == 1 && fs_lit) begin lit(3, 5, 1); fs_lit = 0; end
            if (vcnt == 2 && lock_lit) begin lit(2, 3, 0); lit(3, 3, 1); lock_lit = 0; end
        end
        if (scripted) begin
            if (frame_no == 6 && gc == 0 && gr == 0) begin lit(3, 0, 0); lit(3, 1, 0); lit(3, 3, 1); end
            if (frame_no == 6 && gc == AC && gr == 0) begin lit(3, 0, AC); lit(3, 2, 0); end
            if (frame_no == 6 && gc == 0 && gr == AR) begin lit(3, 1, AR); lit(3, 2, 0); end
            if ((mode == 1 || mode == 2) && gc == 0 && gr == VE) begin lit(3, 4, 1); lit(3, 3, 0); end
            if (mode == 1 && gc == 0 && gr == VE + 1) begin lit(3, 0, 0); lit(3, 1, VE); lit(3, 5, 1); end
            if (mode == 3 && gc == HE - 4 && gr == bad_row) begin
                lit(3, 4, 1); lit(3, 0, HE - 4); lit(3, 1, bad_row);
            end
        end
        gc++;
        if (gc == TC) begin
            gc = 0; gr++;
            if (gr == TR) begin gr = 0; frame_no++; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) model_tick();
        compare();
        gen_drive();
    endtask

    task automatic async_reset_checks();
        chk("rst_col", int'(col), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_active", int'(active), 1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(sync_err), 0);
        chk("rst_frame", int'(frame_start), 0);
        chk("rst_hsync", int'(hs_o), 1);
        chk("rst_vsync", int'(vs_o), 1);
    endtask

    initial begin
        model_reset();
        rc = $urandom_range(0, TC - 1);
        #1 rst = 1;
        #1 async_reset_checks();
        repeat (3) step();
        rst = 0; vcnt = 0; lock_lit = 1; fs_lit = 1;
        while (frame_no < 49 && cyc < 60000) begin
            step();
            if (frame_no == 44 && gr == 6 && gc == rc && !did_rst) begin
                did_rst = 1;
                rst = 1;
                #1;
                model_reset();
                async_reset_checks();
                repeat (3) step();
                rst = 0; vcnt = 0; lock_lit = 1; fs_lit = 1;
            end
        end
        chk("run_complete", frame_no, 49);
        chk("lits_consumed", lits.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync_to_count.md
VGA_SYNC_TO_COUNT -- requirements
Module: vga_sync_to_count

Interface
REQ-001 The block SHALL have parameter TOTAL_COLS, default 800, meaning pixel clocks per line.
REQ-002 The block SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame.
REQ-003 The block SHALL have parameter ACTIVE_COLS, default 640, meaning visible columns (cols 0..ACTIVE_COLS-1).
REQ-004 The block SHALL have parameter ACTIVE_ROWS, default 480, meaning visible rows (rows 0..ACTIVE_ROWS-1).
REQ-005 The block SHALL have parameter H_EDGE_COL, default 656, meaning the column at which an HSync assertion edge is expected.
REQ-006 The block SHALL have parameter V_EDGE_ROW, default 490, meaning the row loaded on a VSync assertion edge.
REQ-007 The block SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning 1 = sync pulses asserted low.
REQ-008 The block SHALL have port i_Clk, input, 1 bit: pixel clock, the only clock.
REQ-009 The block SHALL have port i_Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-010 The block SHALL have ports i_HSync and i_VSync, input, 1 bit each: raw sync pins, possibly from off-board.
REQ-011 The block SHALL have ports o_HSync and o_VSync, output, 1 bit each: sync signals delayed to align with the counts.
REQ-012 The block SHALL have ports o_Col_Count and o_Row_Count, output, 10 bits each: the recovered pixel position.
REQ-013 The block SHALL have port o_Active, output, 1 bit: high when col < ACTIVE_COLS and row < ACTIVE_ROWS.
REQ-014 The block SHALL have port o_Frame_Start, output, 1 bit: one-cycle pulse on each VSync assertion edge.
REQ-015 The block SHALL have port o_Locked, output, 1 bit: high while the lock FSM is in LOCKED.
REQ-016 The block SHALL have port o_Sync_Err, output, 1 bit: one-cycle pulse whenever lock is lost.

Function
REQ-017 Each sync input SHALL pass through a 2-flop synchronizer followed by a 1-flop edge-detect stage; latency from pin to o_HSync/o_VSync, counts and pulses SHALL be 3 i_Clk cycles.
REQ-018 An assertion edge SHALL be prev = deasserted, curr = asserted, with polarity set by SYNC_ACTIVE_LOW.
REQ-019 o_HSync and o_VSync SHALL carry the input pin polarity unchanged.
REQ-020 Free-run counting: col SHALL increment by 1 each cycle; at TOTAL_COLS-1 col SHALL wrap to 0 and row SHALL increment; row at TOTAL_ROWS-1 with a col wrap SHALL wrap to 0.
REQ-021 On a VSync assertion edge, counts SHALL load (col 0, row V_EDGE_ROW) in that cycle; this load SHALL override free-run.
REQ-022 Expected position = the value free-run would have produced that cycle.
REQ-023 o_Active SHALL be combinational from the registered counts.
REQ-024 Lock FSM states SHALL be UNLOCKED, CHECK and LOCKED; reset state is UNLOCKED.
REQ-025 UNLOCKED SHALL move to CHECK on a VSync edge.
REQ-026 CHECK SHALL move to LOCKED on a VSync edge whose expected position equals (0, V_EDGE_ROW); a mismatching edge SHALL keep the FSM in CHECK, with the load still applied.
REQ-027 In LOCKED, a VSync edge at the expected position SHALL keep the FSM in LOCKED.
REQ-028 In LOCKED, any of the following SHALL move the FSM to UNLOCKED and pulse o_Sync_Err for 1 cycle: a VSync edge at a mismatching position; an expected position of (0, V_EDGE_ROW) with no VSync edge (missing edge); an HSync edge with col != H_EDGE_COL.
REQ-029 If HSync and VSync edges fall in the same cycle, the VSync rule SHALL be evaluated first; a matching VSync plus a mismatching HSync SHALL still count as an error.
REQ-030 HSync edges SHALL never modify the counts, only the monitor.
REQ-031 o_Sync_Err SHALL never pulse outside LOCKED.
REQ-032 o_Frame_Start SHALL pulse on every VSync edge regardless of FSM state.

Reset
REQ-033 While i_Rst is high, synchronizer flops SHALL be set to the deasserted level, counts SHALL be 0, o_HSync/o_VSync SHALL be deasserted, o_Frame_Start/o_Locked/o_Sync_Err SHALL be 0, and the FSM SHALL be UNLOCKED.
REQ-034 o_Active SHALL be 1 during reset because counts are (0, 0).
REQ-035 Reset asserted mid-frame SHALL drop lock immediately without an o_Sync_Err pulse.
REQ-036 After release, re-lock SHALL require two VSync edges.

Structure
REQ-037 Shared package vga_timing_pkg SHALL hold the 640x480 constants (800, 525, 640, 480, 656, 490), the count width of 10, and the lock-state enum; the matching VGA sync generator SHALL use the same constants.
REQ-038 One sub-module, sync_edge_detect, SHALL implement the 2-flop synchronizer plus edge-detect stage, instantiated once per sync input.

Verification
REQ-039 Drive a clean 800x525 generator with edges at col 656 and row 490 -> o_Locked rises 3 cycles after the 2nd VSync edge and stays high for 10 frames with no o_Sync_Err.
REQ-040 When locked, check o_Col_Count/o_Row_Count = (0, 0) exactly 3 cycles after the generator outputs pixel (0, 0), and check o_Active low at (640, 0) and (0, 480).
REQ-041 Shift the VSync edge by +1 line while locked -> one o_Sync_Err pulse, o_Locked = 0, counts reload to (0, 490), re-lock after 2 further good frames.
REQ-042 Suppress one VSync pulse while locked -> o_Sync_Err pulses at expected (0, 490), counts keep free-running, and the next VSync edge puts the FSM in CHECK.
REQ-043 Move one HSync edge to col 650 while locked -> error pulse, unlock, and the counts are unchanged by the HSync edge.
REQ-044 Assert i_Rst mid-frame -> all outputs at reset values asynchronously with no o_Sync_Err; after release, o_Frame_Start on the next edge and lock after the second.
